// File: rtl/jpeg_fifo_pkg.sv
// Shared helpers for the JPEG decoder stream FIFO: pointer wrap and level sizing.
package jpeg_fifo_pkg;

  // Advance a storage pointer, wrapping from depth-1 back to 0 (any depth).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Bits needed to hold an occupancy count in the range 0..cap.
  function automatic int unsigned level_width(input int unsigned cap);
    return $clog2(cap + 32'd1);
  endfunction

endpackage

// File: rtl/jpeg_fifo_out_reg.sv
// Output register stage: holds the head word, refilled from storage or by bypass.
module jpeg_fifo_out_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             st_empty_i,
  input  logic [WIDTH-1:0] st_head_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             st_rd_c,
  output logic             bypass_c,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic load_c;

  // Register may take a new word when empty or when its word is leaving.
  assign load_c   = ~out_valid_o | out_ready_i;
  // Storage head has priority; bypass only when storage is empty to keep order.
  assign st_rd_c  = load_c & ~st_empty_i;
  assign bypass_c = load_c & st_empty_i & push_i;

  // Head register: load from storage, else bypass the pushed word, else go empty.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (load_c) begin
      if (!st_empty_i) begin
        out_valid_o <= 1'b1;
        out_data_o  <= st_head_i;
      end else if (push_i) begin
        out_valid_o <= 1'b1;
        out_data_o  <= in_data_i;
      end else begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jpeg_stream_fifo.sv
// Valid/ready stream FIFO with any-integer depth, optional output register and level flags.
module jpeg_stream_fifo
  import jpeg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned OUT_REG       = 1,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_i,
  input  logic                                       in_valid_i,
  input  logic [WIDTH-1:0]                           in_data_i,
  output logic                                       in_ready_o,
  output logic                                       out_valid_o,
  output logic [WIDTH-1:0]                           out_data_o,
  input  logic                                       out_ready_i,
  output logic [level_width(DEPTH+OUT_REG)-1:0]      level_o,
  output logic                                       almost_full_o,
  output logic                                       almost_empty_o
);

  localparam int unsigned CAP     = DEPTH + OUT_REG;
  localparam int unsigned LEVEL_W = level_width(CAP);
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic               st_empty, st_full;
  logic [LEVEL_W-1:0] level;
  logic               push, pop, st_wr, st_rd;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data, st_head;

  assign wr_ptr_nxt = PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
  assign rd_ptr_nxt = PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
  assign st_head    = mem[rd_ptr];

  // Ready depends only on reset and occupancy, never on the downstream side.
  assign in_ready_o = ~rst_i & (level != LEVEL_W'(CAP));
  assign push       = in_valid_i & in_ready_o;
  assign pop        = out_valid & out_ready_i;

  assign out_valid_o    = out_valid;
  assign out_data_o     = out_data;
  assign level_o        = level;
  assign almost_full_o  = (32'(level) >= AFULL_THRESH);
  assign almost_empty_o = (32'(level) <= AEMPTY_THRESH);

  if (OUT_REG != 0) begin : g_out_reg
    logic bypass;

    jpeg_fifo_out_reg #(
      .WIDTH (WIDTH)
    ) u_out_reg (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .st_empty_i  (st_empty),
      .st_head_i   (st_head),
      .push_i      (push),
      .in_data_i   (in_data_i),
      .out_ready_i (out_ready_i),
      .st_rd_c     (st_rd),
      .bypass_c    (bypass),
      .out_valid_o (out_valid),
      .out_data_o  (out_data)
    );

    // A bypassed word goes straight to the head register, not into storage.
    assign st_wr = push & ~bypass & ~st_full;
  end else begin : g_no_out_reg
    assign out_valid = ~st_empty;
    assign out_data  = st_head;
    assign st_rd     = pop;
    assign st_wr     = push & ~st_full;
  end

  // Storage array write port; contents are never cleared.
  always_ff @(posedge clk_i) begin
    if (st_wr) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  // Pointers with explicit full/empty tracking so any depth works.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_empty <= 1'b1;
      st_full  <= 1'b0;
    end else begin
      if (st_wr) wr_ptr <= wr_ptr_nxt;
      if (st_rd) rd_ptr <= rd_ptr_nxt;
      if (st_wr && !st_rd) begin
        st_empty <= 1'b0;
        st_full  <= (wr_ptr_nxt == rd_ptr);
      end else if (st_rd && !st_wr) begin
        st_full  <= 1'b0;
        st_empty <= (rd_ptr_nxt == wr_ptr);
      end
    end
  end

  // Occupancy including the head register.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      level <= '0;
    end else if (push && !pop) begin
      level <= level + LEVEL_W'(1);
    end else if (pop && !push) begin
      level <= level - LEVEL_W'(1);
    end
  end

endmodule

// File: tb/tb_jpeg_stream_fifo.sv
// Bench for jpeg_stream_fifo: registered-output and storage-read variants driven in lockstep.
module tb_jpeg_stream_fifo;

  localparam int unsigned CAP_A = 6;
  localparam int unsigned AF_A  = 5;
  localparam int unsigned AE_A  = 1;
  localparam int unsigned CAP_B = 3;
  localparam int unsigned AF_B  = 2;
  localparam int unsigned AE_B  = 1;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic [15:0] in_data_i;

  logic        a_in_ready, a_out_valid, a_af, a_ae;
  logic [15:0] a_out_data;
  logic [2:0]  a_level;
  logic        b_in_ready, b_out_valid, b_af, b_ae;
  logic [15:0] b_out_data;
  logic [1:0]  b_level;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] emit_a[$];
  bit          last_push_a;

  always #5 clk = ~clk;

  jpeg_stream_fifo #(
    .WIDTH(16), .DEPTH(5), .OUT_REG(1), .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(a_in_ready),
    .out_valid_o(a_out_valid), .out_data_o(a_out_data), .out_ready_i(out_ready_i),
    .level_o(a_level), .almost_full_o(a_af), .almost_empty_o(a_ae)
  );

  jpeg_stream_fifo #(
    .WIDTH(16), .DEPTH(3), .OUT_REG(0), .AEMPTY_THRESH(1)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(b_in_ready),
    .out_valid_o(b_out_valid), .out_data_o(b_out_data), .out_ready_i(out_ready_i),
    .level_o(b_level), .almost_full_o(b_af), .almost_empty_o(b_ae)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare both DUTs against the queue models, then advance the models.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [15:0] d, input logic ordy, input bit chk);
    bit ra, va, rb, vb, pa, pb, oa, ob;
    @(negedge clk);
    rst_i = rst; flush_i = fl; in_valid_i = iv; in_data_i = d; out_ready_i = ordy;
    #1;
    ra = !rst && (qa.size() != CAP_A);
    va = (qa.size() != 0);
    rb = !rst && (qb.size() != CAP_B);
    vb = (qb.size() != 0);
    if (chk) begin
      check("a_in_ready", 32'(a_in_ready), 32'(ra));
      check("a_out_valid", 32'(a_out_valid), 32'(va));
      if (va) check("a_out_data", 32'(a_out_data), 32'(qa[0]));
      check("a_level", 32'(a_level), 32'(qa.size()));
      check("a_almost_full", 32'(a_af), 32'(qa.size() >= AF_A));
      check("a_almost_empty", 32'(a_ae), 32'(qa.size() <= AE_A));
      check("b_in_ready", 32'(b_in_ready), 32'(rb));
      check("b_out_valid", 32'(b_out_valid), 32'(vb));
      if (vb) check("b_out_data", 32'(b_out_data), 32'(qb[0]));
      check("b_level", 32'(b_level), 32'(qb.size()));
      check("b_almost_full", 32'(b_af), 32'(qb.size() >= AF_B));
      check("b_almost_empty", 32'(b_ae), 32'(qb.size() <= AE_B));
    end
    pa = !rst && !fl && iv && ra;
    pb = !rst && !fl && iv && rb;
    oa = !rst && !fl && va && ordy;
    ob = !rst && !fl && vb && ordy;
    if (oa) emit_a.push_back(a_out_data);
    last_push_a = pa;
    @(posedge clk);
    if (rst || fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back(d);
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back(d);
    end
  endtask

  initial begin
    logic [15:0] nxt;
    logic [15:0] exp_seq[$];
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;

    // Reset
    cycle(1, 0, 0, 16'h0, 0, 0);
    cycle(1, 0, 1, 16'h0, 1, 1);
    #2;
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_ae", 32'(a_ae), 32'd1);

    // Fill with no downstream demand
    for (int i = 1; i <= 7; i++) cycle(0, 0, 1, 16'(i), 0, 1);
    #2;
    check("fill_level", 32'(a_level), 32'd6);
    check("fill_ready", 32'(a_in_ready), 32'd0);
    check("fill_af", 32'(a_af), 32'd1);
    check("fill_b_level", 32'(b_level), 32'd3);

    // Full with both handshakes offered: only the pop happens
    emit_a.delete();
    cycle(0, 0, 1, 16'h10, 1, 1);
    #2;
    check("full_pop_level", 32'(a_level), 32'd5);
    check("full_pop_ready", 32'(a_in_ready), 32'd1);

    // Drain while refilling; pointers wrap several times
    nxt = 16'h10;
    for (int i = 0; i < 60 && emit_a.size() < 16; i++) begin
      cycle(0, 0, (nxt <= 16'h19), nxt, 1, 1);
      if (last_push_a) nxt++;
    end
    for (int i = 1; i <= 6; i++) exp_seq.push_back(16'(i));
    for (int i = 16'h10; i <= 16'h19; i++) exp_seq.push_back(16'(i));
    check("drain_count", 32'(emit_a.size()), 32'd16);
    for (int i = 0; i < 16 && i < emit_a.size(); i++)
      check("drain_order", 32'(emit_a[i]), 32'(exp_seq[i]));
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 16'h0, 1, 1);

    // Push into an empty FIFO appears one cycle later
    cycle(0, 0, 1, 16'hABCD, 0, 1);
    #2;
    check("byp_valid", 32'(a_out_valid), 32'd1);
    check("byp_data", 32'(a_out_data), 32'hABCD);
    check("byp_level", 32'(a_level), 32'd1);
    check("byp_ae", 32'(a_ae), 32'd1);
    check("byp_b_data", 32'(b_out_data), 32'hABCD);

    // Flush wins over a simultaneous push and pop
    for (int i = 1; i <= 3; i++) cycle(0, 0, 1, 16'h30 + 16'(i), 0, 1);
    #2;
    check("pre_flush_level", 32'(a_level), 32'd4);
    cycle(0, 1, 1, 16'hDEAD, 1, 1);
    #2;
    check("flush_level", 32'(a_level), 32'd0);
    check("flush_valid", 32'(a_out_valid), 32'd0);
    cycle(0, 0, 1, 16'h0042, 0, 1);
    #2;
    check("post_flush_valid", 32'(a_out_valid), 32'd1);
    check("post_flush_data", 32'(a_out_data), 32'h0042);

    // Reset in the middle of a stream
    cycle(0, 0, 1, 16'h0043, 0, 1);
    cycle(0, 0, 1, 16'h0044, 0, 1);
    #2;
    check("pre_rst_level", 32'(a_level), 32'd3);
    cycle(1, 0, 1, 16'h0055, 1, 1);
    #2;
    check("mid_rst_level", 32'(a_level), 32'd0);
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_ae", 32'(a_ae), 32'd1);
    check("mid_rst_af", 32'(a_af), 32'd0);
    check("mid_rst_ready", 32'(a_in_ready), 32'd0);
    check("mid_rst_b_level", 32'(b_level), 32'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(79) == 0), ($urandom_range(39) == 0),
            ($urandom_range(3) != 0), 16'($urandom), ($urandom_range(2) != 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jpeg_stream_fifo.md
Name: jpeg_stream_fifo

Overview:
Parametrised valid/ready FIFO for the decoder's internal streams: IDCT input/output, Huffman-to-dequant and output pixel paths.
- Storage depth may be any integer; it need not be a power of two.
- An optional registered output stage breaks the combinational path from storage to downstream logic.
- Exposes an occupancy level plus programmable almost-full and almost-empty flags for upstream throttling.
- Drop-in replacement for the existing small FIFOs wherever a depth, timing or flow-control feature is needed.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, storage entries (>=2, any integer).
- OUT_REG, 1, 1 = registered output stage (capacity DEPTH+1); 0 = head read directly from storage (capacity DEPTH).
- AFULL_THRESH, DEPTH-1, almost_full_o asserts when level_o >= this value.
- AEMPTY_THRESH, 1, almost_empty_o asserts when level_o <= this value.
- Derived localparams: CAP = DEPTH+OUT_REG; LEVEL_W = $clog2(CAP+1); PTR_W = $clog2(DEPTH).

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of all contents.
- in_valid_i  in  1  upstream word valid.
- in_data_i  in  WIDTH  upstream word.
- in_ready_o  out  1  FIFO can accept a word this cycle.
- out_valid_o  out  1  head word valid.
- out_data_o  out  WIDTH  head word.
- out_ready_i  in  1  downstream accepts the head.
- level_o  out  LEVEL_W  words held, including the output register.
- almost_full_o  out  1  level_o >= AFULL_THRESH.
- almost_empty_o  out  1  level_o <= AEMPTY_THRESH.

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.

Handshake:
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = !rst_i & (level_o != CAP). It never depends on out_ready_i, so a pop does not free a slot for a push in the same cycle.
- Once out_valid_o is high, it and out_data_o stay stable until popped. Only flush or reset can withdraw them.

Reset:
- On the first edge with rst_i high: pointers, level and output-valid clear to 0, and out_data_o register clears to 0 (OUT_REG=1).
- After that edge: level_o=0, out_valid_o=0, almost_empty_o=1, almost_full_o=(AFULL_THRESH==0).
- Storage array is not reset.
- Reset asserted mid-stream discards all contents. Handshakes in a reset cycle are ignored.

Flush:
- Same clearing as reset.
- Has priority over push and pop in the same cycle; both transfers are discarded.
- in_ready_o is not gated by flush_i, so upstream sees its word as accepted but it is dropped.

Pointers and level:
- Read and write pointers wrap explicitly from DEPTH-1 to 0.
- Storage count uses separate full/empty tracking, correct for non-power-of-2 depths.
- level_o: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags are decoded from the level register (registered-equivalent timing, no input paths).

OUT_REG=0:
- out_valid_o = storage non-empty; out_data_o = mem[rd_ptr].
- Push-to-valid latency is 1 cycle.

OUT_REG=1:
- The output register loads whenever it is empty or being popped.
- Load source is the storage head if storage is non-empty; otherwise the pushed word (bypass). Push-to-out_valid_o latency is 1 cycle, including from empty.
- Strict FIFO ordering: bypass only when storage is empty.
- Full throughput: one push and one pop per cycle sustained when not full.
- out_data_o is driven only from the flop, never combinationally from storage.

Decomposition:
- jpeg_fifo_pkg: ptr_inc function (wrap at DEPTH-1) and a level-width helper function.
- Sub-module jpeg_fifo_out_reg: output register stage (load/hold/bypass select, valid flop).
- Instantiated under a generate on OUT_REG; pass-through when OUT_REG=0.

Test Plan (WIDTH=16, DEPTH=5, OUT_REG=1, AFULL_THRESH=5, AEMPTY_THRESH=1 unless stated):
- Fill: push 0x0001..0x0007 with out_ready_i=0.
  - Required: words 1-6 accepted; in_ready_o=0 after the 6th push; 0x0007 held off; level_o=6.
  - almost_full_o rises on the edge where level_o reaches 5.
- Drain and wrap: from full, pop continuously while pushing 0x0010..0x0019.
  - Required: output sequence 0x0001..0x0006 then 0x0010..0x0019, no gaps, no duplicates.
  - Pointers wrap at least twice.
- Full plus simultaneous handshake: at level 6 with in_valid_i=1 and out_ready_i=1.
  - Required: pop only; level_o=5 next cycle; push accepted the cycle after.
- Bypass latency: empty FIFO, push 0xABCD at cycle N.
  - Required: out_valid_o=1 with 0xABCD at N+1; level_o=1; almost_empty_o=1.
- Flush: level 4, pulse flush_i together with a push of 0xDEAD and a pop.
  - Required next cycle: level_o=0, out_valid_o=0, 0xDEAD never emitted.
  - Subsequent push 0x0042 emerges first.
- Reset and OUT_REG=0: assert rst_i mid-stream at level 3.
  - Required: all outputs at reset values after one edge; in_ready_o=0 while rst_i is high.
  - Repeat scenarios 1–2 with OUT_REG=0, DEPTH=3: capacity 3, data read from storage.
